cam_capture: RTL and testbench
==============================

# cam_capture

Camera-side capture stage feeding the edge filter. Samples an OV7670-style 8-bit parallel RGB565 stream (vsync/href framing, clocked by the camera pixel clock as `clk`), pairs bytes into pixels, converts each to 4-bit grayscale and emits one frame-buffer write per pixel with a linear raster address. It frames capture on vsync so the downstream filter and frame buffer always see whole, address-aligned frames.

## Interface
- `IMG_W`, 640: active pixels per line; pixels past this are dropped.
- `IMG_H`, 480: active lines per frame; lines past this are dropped.
- `clk` input 1: camera pixel clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `capture_en` input 1: arms capture; sampled only in IDLE.
- `cam_vsync` input 1: high during vertical blanking; rising edge ends a frame.
- `cam_href` input 1: high while line bytes are valid.
- `cam_data` input 8: camera byte, valid when `cam_href`=1.
- `frame_pixel` output 4: grayscale pixel, registered.
- `capture_address` output 19: raster address row*IMG_W+col of `frame_pixel`.
- `write_enable` output 1: one-cycle strobe, `frame_pixel`/`capture_address` valid.
- `frame_done` output 1: one-cycle pulse at end of a captured frame.
- `overrun` output 1: sticky; set when a pixel falls outside IMG_W x IMG_H; cleared only by reset.

## Operation
- States: IDLE, SYNC, FRAME.
  - IDLE: `capture_en`=1 -> SYNC.
  - SYNC: wait for `cam_vsync`=1 then `cam_vsync`=0 (falling edge) -> FRAME; clears row, col, address, byte phase. Entering mid-frame never captures a partial frame.
  - FRAME: capture bytes. On `cam_vsync` rising edge: pulse `frame_done` if at least one pixel written this frame; then `capture_en`=1 -> SYNC path (re-clear on next falling edge), else -> IDLE. `capture_en` deassertion inside FRAME has no effect until frame end.
- Byte pairing (FRAME, `cam_href`=1): phase 0 latches byte0; phase 1 forms pixel from byte0/byte1, toggles phase back. Phase resets to 0 whenever `cam_href`=0; an unpaired trailing byte is discarded.
- RGB565: r=byte0[7:3], g={byte0[2:0],byte1[7:5]}, b=byte1[4:0]. r6={r,r[4]}, b6={b,b[4]}. sum (8 bits, no overflow, max 252) = r6 + 2*g + b6. `frame_pixel` = sum[7:4].
- Counters: col increments per completed pixel; on `cam_href` falling edge, if col>0 then row+1, col=0. Address is an incrementing counter (not a multiply), advanced only on written pixels.
- Pixel written only if col<IMG_W and row<IMG_H; otherwise no strobe, address unchanged, `overrun` set.
- Short lines (col<IMG_W at href fall): no padding; next line's address continues from row*IMG_W (address resynced to row*IMG_W+0 at line start via per-line base register).

## Timing
- Reset: state IDLE, `frame_pixel`=0, `capture_address`=0, `write_enable`=0, `frame_done`=0, `overrun`=0, phase 0, row=col=0. Reset mid-frame aborts immediately; no further strobes.
- Latency: byte1 sampled at edge N -> `write_enable`=1 with its pixel/address during cycle N+1 (one register stage).
- Max write rate: one strobe per two clocks; `write_enable` never high two consecutive cycles.
- `frame_done` asserts the cycle after the clock that samples `cam_vsync` rising; never coincides with `write_enable`.
- Last address of a full frame = IMG_W*IMG_H-1 (307199); next frame restarts at 0.

## Test plan
- Reset/idle: `capture_en`=0, drive full frame -> no `write_enable`, all outputs 0.
- Full frame 640x480 of bytes 0xFF,0xFF -> 307200 strobes, pixel=15, addresses 0..307199 contiguous, one `frame_done`.
- Color math: byte pair 0xF8,0x00 (pure red) -> pixel 3; 0x07,0xE0 (pure green) -> 7; 0x00,0x1F (blue) -> 3; 0x00,0x00 -> 0.
- Mid-frame arm: assert `capture_en` during line 100 -> no writes until after next vsync fall; then first write address 0.
- Oversize: 642-pixel lines, 481 lines -> 2 pixels/line and line 481 dropped, `overrun`=1, addresses never exceed 307199; odd byte count per line -> last byte discarded.
- Reset mid-frame at line 200 -> strobes stop next cycle, outputs 0, resumes only after capture_en and fresh vsync.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture
//   Camera-side capture stage feeding the edge filter. Samples an
//   OV7670-style 8-bit RGB565 byte stream framed by vsync/href. It pairs
//   bytes into pixels, converts each pixel to 4-bit grayscale and issues
//   one frame-buffer write per pixel at a linear raster address.
//   Capture is aligned to vsync, so downstream logic only ever sees whole,
//   address-aligned frames.
//
// Parameters
//   IMG_W           active pixels per line (pixels past this are dropped)
//   IMG_H           active lines per frame (lines past this are dropped)
// Ports
//   clk             camera pixel clock; all logic runs on its rising edge
//   rst_n           synchronous active-low reset
//   capture_en      arms capture; sampled only while idle
//   cam_vsync       high during vertical blanking; its rising edge ends a frame
//   cam_href        high while line bytes are valid
//   cam_data        camera byte
//   frame_pixel     registered 4-bit grayscale pixel
//   capture_address raster address row*IMG_W+col of frame_pixel
//   write_enable    one-cycle strobe; frame_pixel/capture_address are valid
//   frame_done      one-cycle pulse at the end of a captured frame
//   overrun         sticky flag: a pixel fell outside IMG_W x IMG_H

module cam_capture #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [3:0]  frame_pixel,
  output logic [18:0] capture_address,
  output logic        write_enable,
  output logic        frame_done,
  output logic        overrun
);

  // The counters get one bit of headroom so they can represent
  // "past the edge". They saturate there instead of wrapping back into range.
  localparam int COL_W  = $clog2(IMG_W) + 1;
  localparam int ROW_W  = $clog2(IMG_H) + 1;
  localparam int ADDR_W = 19;

  localparam logic [COL_W-1:0]  W_LIM   = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0]  H_LIM   = ROW_W'(IMG_H);
  localparam logic [COL_W-1:0]  COL_MAX = {COL_W{1'b1}};
  localparam logic [ROW_W-1:0]  ROW_MAX = {ROW_W{1'b1}};
  localparam logic [ADDR_W-1:0] W_STEP  = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_vsync_q;
  logic                r_href_q;
  logic                r_phase;
  logic [7:0]          r_byte0;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_line_base;
  logic                r_wrote;
  logic [3:0]          r_pixel;
  logic [ADDR_W-1:0]   r_addr_out;
  logic                r_we;
  logic                r_fd;
  logic                r_overrun;

  logic                w_vs_rise;
  logic                w_vs_fall;
  logic                w_href_fall;
  logic                w_frame_start;
  logic                w_frame_end;
  logic                w_in_frame;
  logic                w_pix_done;
  logic                w_in_bounds;
  logic                w_write;
  logic                w_line_end;
  logic [ADDR_W-1:0]   w_next_base;
  logic [3:0]          w_gray;

  // RGB565 -> 4-bit gray. Red and blue are widened to 6 bits and green is
  // weighted x2. This approximates the usual luma weights with adds only.
  function automatic logic [3:0] rgb565_gray(input logic [7:0] b0, input logic [7:0] b1);
    logic [5:0] r6;
    logic [5:0] g6;
    logic [5:0] b6;
    logic [7:0] sum;
    r6  = {b0[7:3], b0[7]};
    g6  = {b0[2:0], b1[7:5]};
    b6  = {b1[4:0], b1[4]};
    sum = 8'(r6) + {1'b0, g6, 1'b0} + 8'(b6);
    return sum[7:4];
  endfunction

  assign w_vs_rise   = cam_vsync & ~r_vsync_q;
  assign w_vs_fall   = ~cam_vsync & r_vsync_q;
  assign w_href_fall = ~cam_href & r_href_q;
  // Bytes that arrive on the clock that closes the frame are ignored. As a
  // result, frame_done can never land in the same cycle as a write strobe.
  assign w_in_frame  = (r_state == ST_FRAME) && !w_vs_rise;
  assign w_pix_done  = w_in_frame && cam_href && r_phase;
  assign w_in_bounds = (r_col < W_LIM) && (r_row < H_LIM);
  assign w_write     = w_pix_done && w_in_bounds;
  assign w_line_end  = w_in_frame && w_href_fall && (r_col != {COL_W{1'b0}});
  assign w_next_base = r_line_base + W_STEP;
  assign w_gray      = rgb565_gray(r_byte0, cam_data);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic and frame start/end events
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_en) begin
          w_state_next = ST_SYNC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SYNC: begin
        // Only a vsync fall can start a frame. Arming mid-frame therefore
        // waits out the rest of the current frame.
        if (w_vs_fall) begin
          w_state_next  = ST_FRAME;
          w_frame_start = 1'b1;
        end else begin
          w_state_next = ST_SYNC;
        end
      end
      ST_FRAME: begin
        if (w_vs_rise) begin
          w_frame_end = 1'b1;
          if (capture_en) begin
            w_state_next = ST_SYNC;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_FRAME;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: byte pairing, raster counters, address tracking and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync_q   <= 1'b0;
      r_href_q    <= 1'b0;
      r_phase     <= 1'b0;
      r_byte0     <= 8'h00;
      r_col       <= {COL_W{1'b0}};
      r_row       <= {ROW_W{1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_line_base <= {ADDR_W{1'b0}};
      r_wrote     <= 1'b0;
      r_pixel     <= 4'h0;
      r_addr_out  <= {ADDR_W{1'b0}};
      r_we        <= 1'b0;
      r_fd        <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vsync_q <= cam_vsync;
      r_href_q  <= cam_href;
      r_we      <= w_write;
      r_fd      <= w_frame_end && r_wrote;

      if (w_frame_start) begin
        r_phase     <= 1'b0;
        r_col       <= {COL_W{1'b0}};
        r_row       <= {ROW_W{1'b0}};
        r_addr      <= {ADDR_W{1'b0}};
        r_line_base <= {ADDR_W{1'b0}};
        r_wrote     <= 1'b0;
      end else if (w_in_frame) begin
        if (cam_href) begin
          if (!r_phase) begin
            r_byte0 <= cam_data;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_col != COL_MAX) begin
              r_col <= r_col + {{(COL_W-1){1'b0}}, 1'b1};
            end
            if (w_write) begin
              r_pixel    <= w_gray;
              r_addr_out <= r_addr;
              r_addr     <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              r_wrote    <= 1'b1;
            end else begin
              r_overrun  <= 1'b1;
            end
          end
        end else begin
          // Clearing the phase here discards an unpaired trailing byte.
          r_phase <= 1'b0;
          if (w_line_end) begin
            r_col <= {COL_W{1'b0}};
            if (r_row != ROW_MAX) begin
              r_row <= r_row + {{(ROW_W-1){1'b0}}, 1'b1};
            end
            // Resync to the next line base, so a short line leaves a gap
            // in the frame buffer instead of shifting every later line.
            if (r_row < H_LIM) begin
              r_line_base <= w_next_base;
              r_addr      <= w_next_base;
            end
          end
        end
      end
    end
  end

  assign frame_pixel     = r_pixel;
  assign capture_address = r_addr_out;
  assign write_enable    = r_we;
  assign frame_done      = r_fd;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture. It uses a reduced 8x4 frame, so full-frame
// and oversize cases stay short. Expected writes are pushed to a queue as
// bytes are driven. A monitor pops and compares each write on the falling
// edge of clk.

module tb_cam_capture;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [3:0]  frame_pixel;
  logic [18:0] capture_address;
  logic        write_enable;
  logic        frame_done;
  logic        overrun;

  cam_capture #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture_en      (capture_en),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_data        (cam_data),
    .frame_pixel     (frame_pixel),
    .capture_address (capture_address),
    .write_enable    (write_enable),
    .frame_done      (frame_done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pix;
    logic [18:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_we     = 0;
  int   n_fd     = 0;
  int   exp_fd   = 0;
  bit   pend_fd  = 1'b0;
  logic prev_we  = 1'b0;

  logic [7:0] tbl0 [4] = '{8'hF8, 8'h07, 8'h00, 8'h00};
  logic [7:0] tbl1 [4] = '{8'h00, 8'hE0, 8'h1F, 8'h00};

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference gray conversion, written directly from the RGB565 formula.
  function automatic logic [3:0] gray(input logic [7:0] b0, input logic [7:0] b1);
    int r, g, b, sum;
    r   = int'(b0[7:3]);
    g   = int'({b0[2:0], b1[7:5]});
    b   = int'(b1[4:0]);
    sum = (r * 2 + (r >> 4)) + 2 * g + (b * 2 + (b >> 4));
    return 4'((sum >> 4) & 15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor. It also checks spacing between strobes and that
  // frame_done never coincides with a write.
  always @(negedge clk) begin
    if (write_enable) begin
      exp_t e;
      n_we++;
      check("we_gap", {31'd0, prev_we}, 32'd0);
      check("we_vs_fd", {31'd0, frame_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel", {28'd0, frame_pixel}, {28'd0, e.pix});
        check("addr", {13'd0, capture_address}, {13'd0, e.addr});
      end
    end
    if (frame_done) n_fd++;
    prev_we = write_enable;
  end

  task automatic vsync_pulse();
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    if (pend_fd) exp_fd++;
    pend_fd = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix"}, {28'd0, frame_pixel}, 32'd0);
    check({tag, "_addr"}, {13'd0, capture_address}, 32'd0);
    check({tag, "_we"}, {31'd0, write_enable}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  // Sends one frame, led by its own vsync pulse. mode selects the data:
  // 0 = all 0xFF, 1 = colour table, 2 = random. cap says whether the
  // design should capture this frame.
  task automatic send_frame(input int lines, input int npix, input bit odd, input int mode,
                            input bit cap_in, input int arm_line, input int dis_line,
                            input int rst_line);
    bit cap;
    int pushed;
    logic [7:0] b0, b1;
    exp_t e;
    cap = cap_in;
    pushed = 0;
    vsync_pulse();
    for (int r = 0; r < lines; r++) begin
      if (r == arm_line) capture_en = 1'b1;
      if (r == dis_line) capture_en = 1'b0;
      if (r == rst_line) begin
        rst_n = 1'b0;
        tick();
        check_outputs_zero("rst_mid");
        rst_n = 1'b1;
        cap = 1'b0;
        pushed = 0;
      end
      for (int c = 0; c < npix; c++) begin
        case (mode)
          0: begin b0 = 8'hFF; b1 = 8'hFF; end
          1: begin b0 = tbl0[(r * npix + c) % 4]; b1 = tbl1[(r * npix + c) % 4]; end
          default: begin b0 = 8'($urandom); b1 = 8'($urandom); end
        endcase
        if (cap && c < W && r < H) begin
          e.pix  = gray(b0, b1);
          e.addr = 19'(r * W + c);
          sb.push_back(e);
          pushed++;
        end
        cam_href = 1'b1;
        cam_data = b0;
        tick();
        cam_data = b1;
        tick();
      end
      if (odd) begin
        cam_href = 1'b1;
        cam_data = 8'($urandom);
        tick();
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (3) tick();
    end
    pend_fd = cap && (pushed > 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Capture disabled: a whole frame produces nothing.
    send_frame(H, W, 1'b0, 0, 1'b0, -1, -1, -1);
    vsync_pulse();
    check("idle_we_count", n_we, 32'd0);
    check_outputs_zero("idle");

    // Arm during line 1: that frame is skipped. The next frame is captured
    // even though capture_en drops part-way through it.
    send_frame(H, W, 1'b0, 0, 1'b0, 1, -1, -1);
    check("midarm_no_we", n_we, 32'd0);
    send_frame(H, W, 1'b0, 0, 1'b1, -1, 1, -1);
    vsync_pulse();
    repeat (2) tick();
    check("full_we_count", n_we, 32'(W * H));
    check("full_last_addr", {13'd0, capture_address}, 32'(W * H - 1));
    check("full_fd", n_fd, exp_fd);
    check("full_sb_empty", sb.size(), 32'd0);

    // Colour table, short lines, then oversize lines with an odd byte.
    capture_en = 1'b1;
    send_frame(H, W, 1'b0, 1, 1'b1, -1, -1, -1);
    send_frame(H, 5, 1'b0, 2, 1'b1, -1, -1, -1);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);
    send_frame(H + 1, W + 2, 1'b1, 2, 1'b1, -1, -1, -1);
    vsync_pulse();
    repeat (2) tick();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("ovr_fd", n_fd, exp_fd);
    check("ovr_sb_empty", sb.size(), 32'd0);

    // Reset at line 2. Capture resumes only at the frame after the next vsync.
    send_frame(H, W, 1'b0, 2, 1'b1, -1, -1, 2);
    check("rst_sb_empty", sb.size(), 32'd0);
    send_frame(H, W, 1'b0, 2, 1'b1, -1, -1, -1);
    capture_en = 1'b0;
    vsync_pulse();
    repeat (4) tick();
    check("final_fd", n_fd, exp_fd);
    check("final_sb_empty", sb.size(), 32'd0);
    check("final_last_addr", {13'd0, capture_address}, 32'(W * H - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
